// File: rtl/stopwatch_cmd_fsm.sv
// Stopwatch run/stop/clear/lap controller driven by debounced buttons and
// UART command bytes from a FWFT RX FIFO, with an optional ack/nak byte per command.
module stopwatch_cmd_fsm #(
    parameter int                DATA_W      = 8,
    parameter int                CLR_CYCLES  = 4,
    parameter logic [DATA_W-1:0] CMD_RUN     = DATA_W'(8'h72),
    parameter logic [DATA_W-1:0] CMD_STOP    = DATA_W'(8'h73),
    parameter logic [DATA_W-1:0] CMD_CLEAR   = DATA_W'(8'h63),
    parameter logic [DATA_W-1:0] CMD_LAP     = DATA_W'(8'h6C),
    parameter bit                CASE_INSENS = 1'b1,
    parameter bit                ACK_EN      = 1'b1,
    parameter logic [DATA_W-1:0] NAK_CHAR    = DATA_W'(8'h3F)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_run,
    input  logic              btn_clear,
    input  logic              btn_lap,
    input  logic              i_fifo_empty,
    input  logic [DATA_W-1:0] i_fifo_data,
    output logic              o_fifo_rd_en,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_run_on,
    output logic              o_clr_on,
    output logic              o_lap_on
);

    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_LAP   = 2'd2;
    localparam logic [1:0] ST_CLEAR = 2'd3;

    localparam logic [2:0] EV_NONE  = 3'd0;
    localparam logic [2:0] EV_RUN   = 3'd1;
    localparam logic [2:0] EV_STOP  = 3'd2;
    localparam logic [2:0] EV_LAP   = 3'd3;
    localparam logic [2:0] EV_CLEAR = 3'd4;

    localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    localparam logic [DATA_W-1:0] CASE_BIT = DATA_W'(8'h20);
    localparam logic [DATA_W-1:0] UC_LO    = DATA_W'(8'h41);
    localparam logic [DATA_W-1:0] UC_HI    = DATA_W'(8'h5A);

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic [CW-1:0]     clr_cnt;
    logic [DATA_W-1:0] norm_byte;
    logic [DATA_W-1:0] ack_byte;
    logic [2:0]        ev;
    logic              ev_ok;
    logic              btn_any;

    // Holding the ack byte blocks further pops, so unread bytes stay queued in the FIFO.
    assign o_fifo_rd_en = !reset && !i_fifo_empty && (state != ST_CLEAR) &&
                          !(ACK_EN && o_tx_valid);

    assign o_run_on = (state == ST_RUN) || (state == ST_LAP);
    assign o_clr_on = (state == ST_CLEAR);
    assign o_lap_on = (state == ST_LAP);

    always_comb begin
        norm_byte = i_fifo_data;
        if (CASE_INSENS && (i_fifo_data >= UC_LO) && (i_fifo_data <= UC_HI))
            norm_byte = i_fifo_data | CASE_BIT;
    end

    // Buttons outrank a byte popped in the same cycle; that byte is still consumed and NAKed.
    always_comb begin
        ev      = EV_NONE;
        btn_any = btn_clear | btn_run | btn_lap;
        if (state != ST_CLEAR) begin
            if (btn_clear)
                ev = EV_CLEAR;
            else if (btn_run)
                ev = (state == ST_STOP) ? EV_RUN : EV_STOP;
            else if (btn_lap)
                ev = EV_LAP;
            else if (o_fifo_rd_en) begin
                if (norm_byte == CMD_RUN)
                    ev = EV_RUN;
                else if (norm_byte == CMD_STOP)
                    ev = EV_STOP;
                else if (norm_byte == CMD_CLEAR)
                    ev = EV_CLEAR;
                else if (norm_byte == CMD_LAP)
                    ev = EV_LAP;
            end
        end
    end

    always_comb begin
        next_state = state;
        ev_ok      = 1'b0;
        case (ev)
            EV_RUN: begin
                if (state == ST_STOP) begin
                    next_state = ST_RUN;
                    ev_ok      = 1'b1;
                end
            end
            EV_STOP: begin
                if ((state == ST_RUN) || (state == ST_LAP)) begin
                    next_state = ST_STOP;
                    ev_ok      = 1'b1;
                end
            end
            EV_LAP: begin
                if (state == ST_RUN) begin
                    next_state = ST_LAP;
                    ev_ok      = 1'b1;
                end else if (state == ST_LAP) begin
                    next_state = ST_RUN;
                    ev_ok      = 1'b1;
                end
            end
            EV_CLEAR: begin
                if (state == ST_STOP) begin
                    next_state = ST_CLEAR;
                    ev_ok      = 1'b1;
                end
            end
            default: ;
        endcase
        if ((state == ST_CLEAR) && (clr_cnt == '0))
            next_state = ST_STOP;
        ack_byte = (ev_ok && !btn_any) ? (norm_byte & ~CASE_BIT) : NAK_CHAR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_STOP;
            clr_cnt    <= '0;
            o_tx_valid <= 1'b0;
            o_tx_data  <= '0;
        end else begin
            state <= next_state;
            if ((state != ST_CLEAR) && (next_state == ST_CLEAR))
                clr_cnt <= CW'(CLR_CYCLES - 1);
            else if ((state == ST_CLEAR) && (clr_cnt != '0))
                clr_cnt <= clr_cnt - 1'b1;
            if (ACK_EN && o_fifo_rd_en) begin
                o_tx_valid <= 1'b1;
                o_tx_data  <= ack_byte;
            end else if (o_tx_valid && i_tx_ready) begin
                o_tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_cmd_fsm.sv
// Directed bench for stopwatch_cmd_fsm: a queue stands in for the RX FIFO and
// every check is an immediate assertion against a hand-computed value.
module tb_stopwatch_cmd_fsm;

    logic       clk;
    logic       reset;
    logic       btn_run;
    logic       btn_clear;
    logic       btn_lap;
    logic       i_fifo_empty;
    logic [7:0] i_fifo_data;
    logic       o_fifo_rd_en;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready;
    logic       o_run_on;
    logic       o_clr_on;
    logic       o_lap_on;

    int tests_run;
    int tests_failed;
    int pop_count;
    int back_to_back;
    logic prev_pop;
    logic [7:0] fifo_q[$];
    logic [7:0] ack_q[$];

    stopwatch_cmd_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .btn_run      (btn_run),
        .btn_clear    (btn_clear),
        .btn_lap      (btn_lap),
        .i_fifo_empty (i_fifo_empty),
        .i_fifo_data  (i_fifo_data),
        .o_fifo_rd_en (o_fifo_rd_en),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .i_tx_ready   (i_tx_ready),
        .o_run_on     (o_run_on),
        .o_clr_on     (o_clr_on),
        .o_lap_on     (o_lap_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic refreshFifo();
        i_fifo_empty = (fifo_q.size() == 0);
        i_fifo_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        fifo_q.push_back(b);
        refreshFifo();
        #1;
    endtask

    // Samples pop and handshake before the edge, then updates the FIFO model after it.
    task automatic tick();
        logic popped;
        logic hs;
        logic [7:0] d;
        @(negedge clk);
        popped = o_fifo_rd_en;
        hs     = o_tx_valid && i_tx_ready;
        d      = o_tx_data;
        @(posedge clk);
        #1;
        if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (popped) pop_count++;
        if (popped && prev_pop) back_to_back++;
        prev_pop = popped;
        if (hs) ack_q.push_back(d);
        refreshFifo();
    endtask

    task automatic pulse(input int which);
        if (which == 0) btn_run = 1'b1;
        if (which == 1) btn_clear = 1'b1;
        if (which == 2) btn_lap = 1'b1;
        tick();
        btn_run = 1'b0;
        btn_clear = 1'b0;
        btn_lap = 1'b0;
        #1;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        pop_count = 0;
        back_to_back = 0;
        prev_pop = 1'b0;
        reset = 1'b1;
        btn_run = 1'b0;
        btn_clear = 1'b0;
        btn_lap = 1'b0;
        i_tx_ready = 1'b0;
        refreshFifo();
        tick();
        tick();

        checkOutput("reset_run", {31'd0, o_run_on}, 0);
        checkOutput("reset_clr", {31'd0, o_clr_on}, 0);
        checkOutput("reset_lap", {31'd0, o_lap_on}, 0);
        checkOutput("reset_valid", {31'd0, o_tx_valid}, 0);
        checkOutput("reset_data", {24'd0, o_tx_data}, 32'h00);

        // Run command, ack, handshake
        reset = 1'b0;
        i_tx_ready = 1'b1;
        applyStimulus(8'h72);
        checkOutput("r_rd_en", {31'd0, o_fifo_rd_en}, 1);
        tick();
        checkOutput("r_run", {31'd0, o_run_on}, 1);
        checkOutput("r_valid", {31'd0, o_tx_valid}, 1);
        checkOutput("r_ack", {24'd0, o_tx_data}, 32'h52);
        checkOutput("r_rd_en_after", {31'd0, o_fifo_rd_en}, 0);
        tick();
        checkOutput("r_valid_drop", {31'd0, o_tx_valid}, 0);

        // Lap by button, back to run with uppercase 'L', stop with 's'
        pulse(2);
        checkOutput("lap_btn_lap", {31'd0, o_lap_on}, 1);
        checkOutput("lap_btn_run", {31'd0, o_run_on}, 1);
        applyStimulus(8'h4C);
        tick();
        checkOutput("L_lap", {31'd0, o_lap_on}, 0);
        checkOutput("L_run", {31'd0, o_run_on}, 1);
        checkOutput("L_ack", {24'd0, o_tx_data}, 32'h4C);
        tick();
        applyStimulus(8'h73);
        tick();
        checkOutput("s_run", {31'd0, o_run_on}, 0);
        checkOutput("s_ack", {24'd0, o_tx_data}, 32'h53);
        tick();

        // Clear rejected in RUN, then timed clear from STOP
        pulse(0);
        checkOutput("btn_run_on", {31'd0, o_run_on}, 1);
        applyStimulus(8'h63);
        tick();
        checkOutput("c_in_run_state", {31'd0, o_run_on}, 1);
        checkOutput("c_in_run_ack", {24'd0, o_tx_data}, 32'h3F);
        tick();
        pulse(0);
        checkOutput("btn_stop", {31'd0, o_run_on}, 0);
        pulse(1);
        applyStimulus(8'h72);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("clear_c%0d_clr", i), {31'd0, o_clr_on}, 1);
            checkOutput($sformatf("clear_c%0d_run", i), {31'd0, o_run_on}, 0);
            checkOutput($sformatf("clear_c%0d_rd", i), {31'd0, o_fifo_rd_en}, 0);
            tick();
        end
        checkOutput("clear_end_clr", {31'd0, o_clr_on}, 0);
        checkOutput("clear_end_rd", {31'd0, o_fifo_rd_en}, 1);
        tick();
        checkOutput("post_clear_run", {31'd0, o_run_on}, 1);
        checkOutput("post_clear_ack", {24'd0, o_tx_data}, 32'h52);
        tick();
        applyStimulus(8'h73);
        tick();
        tick();
        checkOutput("stop_again", {31'd0, o_run_on}, 0);

        // Backpressure: "rsx" queued while TX is stalled
        i_tx_ready = 1'b0;
        pop_count = 0;
        back_to_back = 0;
        fifo_q.push_back(8'h72);
        fifo_q.push_back(8'h73);
        applyStimulus(8'h78);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("bp_pops", pop_count, 1);
        checkOutput("bp_valid", {31'd0, o_tx_valid}, 1);
        checkOutput("bp_hold", {24'd0, o_tx_data}, 32'h52);
        checkOutput("bp_fifo_left", fifo_q.size(), 2);
        ack_q.delete();
        i_tx_ready = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) tick();
        checkOutput("bp_total_pops", pop_count, 3);
        checkOutput("bp_spacing", back_to_back, 0);
        checkOutput("bp_ack_count", ack_q.size(), 3);
        if (ack_q.size() == 3) begin
            checkOutput("bp_ack0", {24'd0, ack_q[0]}, 32'h52);
            checkOutput("bp_ack1", {24'd0, ack_q[1]}, 32'h53);
            checkOutput("bp_ack2", {24'd0, ack_q[2]}, 32'h3F);
        end
        checkOutput("bp_final_run", {31'd0, o_run_on}, 0);
        checkOutput("bp_final_clr", {31'd0, o_clr_on}, 0);

        // Button wins over a popped byte
        btn_run = 1'b1;
        applyStimulus(8'h73);
        checkOutput("prio_rd", {31'd0, o_fifo_rd_en}, 1);
        tick();
        btn_run = 1'b0;
        #1;
        checkOutput("prio_run", {31'd0, o_run_on}, 1);
        checkOutput("prio_ack", {24'd0, o_tx_data}, 32'h3F);
        checkOutput("prio_valid", {31'd0, o_tx_valid}, 1);
        checkOutput("prio_consumed", fifo_q.size(), 0);
        tick();

        // Reset during CLEAR with a pending ack
        pulse(0);
        i_tx_ready = 1'b0;
        btn_clear = 1'b1;
        applyStimulus(8'h63);
        tick();
        btn_clear = 1'b0;
        #1;
        checkOutput("rc_clr", {31'd0, o_clr_on}, 1);
        checkOutput("rc_valid", {31'd0, o_tx_valid}, 1);
        checkOutput("rc_ack", {24'd0, o_tx_data}, 32'h3F);
        applyStimulus(8'h72);
        tick();
        checkOutput("rc_clr2", {31'd0, o_clr_on}, 1);
        reset = 1'b1;
        #1;
        checkOutput("rc_rd_in_reset", {31'd0, o_fifo_rd_en}, 0);
        tick();
        checkOutput("rr_run", {31'd0, o_run_on}, 0);
        checkOutput("rr_clr", {31'd0, o_clr_on}, 0);
        checkOutput("rr_lap", {31'd0, o_lap_on}, 0);
        checkOutput("rr_valid", {31'd0, o_tx_valid}, 0);
        checkOutput("rr_data", {24'd0, o_tx_data}, 32'h00);
        checkOutput("rr_rd", {31'd0, o_fifo_rd_en}, 0);
        checkOutput("rr_fifo_kept", fifo_q.size(), 1);
        reset = 1'b0;
        i_tx_ready = 1'b1;
        #1;
        checkOutput("after_reset_rd", {31'd0, o_fifo_rd_en}, 1);
        tick();
        checkOutput("after_reset_run", {31'd0, o_run_on}, 1);
        checkOutput("after_reset_ack", {24'd0, o_tx_data}, 32'h52);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
